vga_timing_generator: RTL
=========================

// Module: vga_timing_generator
// PURPOSE
//  Parametrised successor to the horizontal-only sync generator: produces both
//  horizontal and vertical VGA sync, the display-enable window, pixel coordinates
//  and frame/line markers from one system clock. Sits between the clock/reset
//  source and the pixel/colour logic; downstream blocks use pixel_x/pixel_y and
//  display to fetch and drive RGB.
// PARAMETERS
//  H_DISPLAY  640  visible pixels per line
//  H_FRONT    16   horizontal front porch (pixels)
//  H_SYNC     96   horizontal sync width (pixels)
//  H_BACK     48   horizontal back porch (pixels)
//  V_DISPLAY  480  visible lines per frame
//  V_FRONT    10   vertical front porch (lines)
//  V_SYNC     2    vertical sync width (lines)
//  V_BACK     33   vertical back porch (lines)
//  CLK_DIV    2    clk cycles per pixel (>=1); 50 MHz clk -> 25 MHz pixel rate
//  SYNC_POL   0    active level of hsynq/vsynq (0 = active-low)
//  CNT_W      10   counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk          in   1      system clock
//  reset        in   1      synchronous, active-high reset
//  enable       in   1      1 = run; 0 = freeze all counters and outputs
//  hsynq        out  1      horizontal sync, level SYNC_POL when active
//  vsynq        out  1      vertical sync, level SYNC_POL when active
//  display      out  1      1 inside the visible H_DISPLAY x V_DISPLAY window
//  pixel_x      out  CNT_W  current horizontal count (0..H_TOTAL-1)
//  pixel_y      out  CNT_W  current vertical count (0..V_TOTAL-1)
//  pixel_start  out  1      1 on the first clk of each pixel period
//  line_start   out  1      pixel_start AND pixel_x==0
//  frame_start  out  1      pixel_start AND pixel_x==0 AND pixel_y==0
// BEHAVIOUR
//  - H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
//  - Internal state: div_cnt (0..CLK_DIV-1), h_cnt, v_cnt.
//  - div_cnt increments each clk while enable=1 and wraps CLK_DIV-1 -> 0.
//    tick = enable AND div_cnt==CLK_DIV-1.
//  - On tick, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
//    At V_TOTAL-1 v_cnt wraps to 0 on the same tick. CLK_DIV=1 gives tick=enable.
//  - Decode uses counters: h active-sync when
//    H_DISPLAY+H_FRONT <= h_cnt < H_DISPLAY+H_FRONT+H_SYNC; v sync uses the same
//    rule with V_*. display = h_cnt<H_DISPLAY AND v_cnt<V_DISPLAY.
//    pixel_start = div_cnt==0.
//  - All outputs are registered with exactly 1 clk latency behind the internal
//    counters. pixel_x/pixel_y are the registered copies of h_cnt/v_cnt, so
//    every output is mutually aligned.
//  - enable=0: div_cnt, h_cnt, v_cnt and all output registers hold.
//    pixel_start, line_start and frame_start also hold their value; they are not
//    re-pulsed.
//  - Reset, from any state including mid-line: all counters go to 0. hsynq and
//    vsynq go to ~SYNC_POL, display=0, pixel_x=pixel_y=0, all *_start=0.
//    reset overrides enable.
//  - First clk after reset deassert (enable=1): counters at (0,0,div 0).
//    Next clk: display=1, frame_start=line_start=pixel_start=1.
//  - hsynq is active for H_SYNC*CLK_DIV clks per line, with period
//    H_TOTAL*CLK_DIV clks. vsynq is active for V_SYNC full lines per frame.
//  - No illegal states: counters only take values in range; the wrap compares
//    use ==, with no overflow reliance.
// TESTING
//  1 Defaults, reset 5 clks then release, enable=1 -> frame_start at clk 2 after
//    release; then 1280 clks display=1, 32 clks display=0, 192 clks hsynq=0,
//    96 clks display=0; line period 1600 clks.
//  2 Defaults, run 1 frame -> vsynq=0 for exactly 3200 clks starting when
//    pixel_y=490, pixel_x=0. Next frame_start 840000 clks after the previous.
//    display never 1 while pixel_y>=480.
//  3 Assert reset for 1 clk at pixel_x=700, pixel_y=300 -> next clk hsynq=1,
//    display=0, pixel_x=pixel_y=0; clk after that frame_start=1.
//  4 Drop enable for 50 clks at pixel_x=100 -> all outputs frozen; on re-enable,
//    counting resumes from 100 and the line lasts exactly 1600+50 clks.
//  5 CLK_DIV=1, SYNC_POL=1 -> pixel_start constantly 1; hsynq=1 for 96 clks per
//    800-clk line; idle level 0 after reset.
//  6 Small override H_*=4,1,2,1; V_*=3,1,1,1 -> pixel_x wraps 7->0 and pixel_y
//    wraps 5->0; frame period 48*CLK_DIV clks.

Source files
------------

// File: rtl/vga_timing_generator.sv
// -----------------------------------------------------------------------------
// vga_timing_generator
//
// Generates horizontal/vertical VGA sync, the display-enable window, pixel
// coordinates and pixel/line/frame start markers from a single system clock.
// A clock divider produces one pixel period every CLK_DIV clk cycles; the
// horizontal and vertical counters advance once per pixel period.
//
// Every output is a register loaded from a decode of the internal counters, so
// all outputs trail the counters by exactly one clk and are mutually aligned.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset (overrides enable)
//   enable       in   1 = run, 0 = freeze counters and all outputs
//   hsynq        out  horizontal sync, level SYNC_POL while active
//   vsynq        out  vertical sync, level SYNC_POL while active
//   display      out  1 inside the visible H_DISPLAY x V_DISPLAY window
//   pixel_x      out  horizontal count, 0..H_TOTAL-1
//   pixel_y      out  vertical count, 0..V_TOTAL-1
//   pixel_start  out  1 on the first clk of each pixel period
//   line_start   out  pixel_start at pixel_x == 0
//   frame_start  out  line_start at pixel_y == 0
// -----------------------------------------------------------------------------
module vga_timing_generator #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2,
    parameter bit SYNC_POL  = 1'b0,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             hsynq,
    output logic             vsynq,
    output logic             display,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             pixel_start,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VISIBLE  = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VISIBLE  = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    logic tick;
    logic h_wrap;
    logic v_wrap;
    logic h_sync_act;
    logic v_sync_act;
    logic display_nxt;
    logic pixel_start_nxt;
    logic line_start_nxt;
    logic frame_start_nxt;

    // Decode of the current counter state; registered below.
    always_comb begin
        tick            = enable && (div_cnt == DIV_LAST);
        h_wrap          = (h_cnt == H_LAST);
        v_wrap          = (v_cnt == V_LAST);
        h_sync_act      = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        v_sync_act      = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        display_nxt     = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
        pixel_start_nxt = (div_cnt == '0);
        line_start_nxt  = pixel_start_nxt && (h_cnt == '0);
        frame_start_nxt = line_start_nxt && (v_cnt == '0);
    end

    // Pixel divider and raster counters. Wraps use equality against the last
    // legal value, so the counters never leave their range.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (enable) begin
            if (tick) begin
                div_cnt <= '0;
                if (h_wrap) begin
                    h_cnt <= '0;
                    v_cnt <= v_wrap ? '0 : v_cnt + CNT_W'(1);
                end else begin
                    h_cnt <= h_cnt + CNT_W'(1);
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Output registers: one clk behind the counters. With enable low they
    // hold, so the start markers stay at their last value instead of pulsing.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsynq       <= ~SYNC_POL;
            vsynq       <= ~SYNC_POL;
            display     <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_start <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            hsynq       <= h_sync_act ? SYNC_POL : ~SYNC_POL;
            vsynq       <= v_sync_act ? SYNC_POL : ~SYNC_POL;
            display     <= display_nxt;
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            pixel_start <= pixel_start_nxt;
            line_start  <= line_start_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule
